// File: rtl/big_core_pkg.sv
// Shared big_core definitions used by the D_MEM DMA initiator.
// Contents: D_MEM region constants, DMA FSM state enum, the full-word byte
// enable, and a helper that tests one byte address against the D_MEM region.
package big_core_pkg;

  // Address bits that select a memory region, and the D_MEM window within them.
  localparam int unsigned MSB_REGION         = 31;
  localparam int unsigned LSB_REGION         = 0;
  localparam logic [31:0] D_MEM_REGION_FLOOR = 32'h0001_0000;
  localparam logic [31:0] D_MEM_REGION_ROOF  = 32'h0001_FFFF;

  // The DMA only moves whole words.
  localparam logic [3:0]  DMA_WORD_BYTEEN    = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } dma_state_t;

  // True when the region bits of addr fall inside the D_MEM window.
  function automatic logic in_dmem_region(input logic [31:0] addr);
    logic [31:0] floor_v;
    logic [31:0] roof_v;
    floor_v = D_MEM_REGION_FLOOR;
    roof_v  = D_MEM_REGION_ROOF;
    return (addr[MSB_REGION:LSB_REGION] >= floor_v[MSB_REGION:LSB_REGION]) &&
           (addr[MSB_REGION:LSB_REGION] <= roof_v[MSB_REGION:LSB_REGION]);
  endfunction

endpackage

// File: rtl/big_core_dma_rng_chk.sv
// Combinational range check for one DMA burst.
// Ports:
//   start_addr : word-aligned byte address of the first word
//   len        : word count (must be non-zero for the result to mean anything)
//   pass_c     : 1 when first and last word both lie in D_MEM and the end
//                address does not wrap past 2^32
module big_core_dma_rng_chk
  import big_core_pkg::*;
#(
  parameter int unsigned LEN_W = 16
) (
  input  logic [31:0]      start_addr,
  input  logic [LEN_W-1:0] len,
  output logic             pass_c
);

  logic [LEN_W-1:0] len_m1;
  logic [32:0]      end_addr;

  // Last word address = start + 4*(len-1); bit 32 is the carry out.
  always_comb begin
    len_m1   = len - LEN_W'(1);
    end_addr = {1'b0, start_addr} + 33'({len_m1, 2'b00});
    pass_c   = !end_addr[32] &&
               in_dmem_region(start_addr) &&
               in_dmem_region(end_addr[31:0]);
  end

endmodule

// File: rtl/big_core_dmem_dma.sv
// Word-copy DMA initiator on the big_core D_MEM request port (Q103H request,
// Q104H response). Alternates read/write requests, shares the port with the
// core via DmaReq/DmaGnt, reports Done (pulse) and Err (sticky).
// Optional feature macro: BIG_CORE_DMA_FILL_EN enables fill mode (FillMode /
// FillData at Start write a constant pattern, 1 cycle/word, dst-only check).
// Ports:
//   Clk, Rst (async, active-low)
//   Start, SrcAddr, DstAddr, Len, FillMode, FillData : command
//   Busy, Done, Err                                  : status
//   DmaReq, DmaGnt                                   : port arbitration
//   DMem*Q103H out, DMemRdRspQ104H in                : D_MEM interface
// Strobes, address and write data are combinational so they can follow
// DmaGnt in the same cycle; all of them decode from registered state.
module big_core_dmem_dma
  import big_core_pkg::*;
#(
  parameter int unsigned LEN_W = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [31:0]      SrcAddr,
  input  logic [31:0]      DstAddr,
  input  logic [LEN_W-1:0] Len,
  input  logic             FillMode,
  input  logic [31:0]      FillData,
  output logic             Busy,
  output logic             Done,
  output logic             Err,
  output logic             DmaReq,
  input  logic             DmaGnt,
  output logic [31:0]      DMemAddressQ103H,
  output logic [31:0]      DMemWrDataQ103H,
  output logic [3:0]       DMemByteEnQ103H,
  output logic             DMemWrEnQ103H,
  output logic             DMemRdEnQ103H,
  input  logic [31:0]      DMemRdRspQ104H
);

  dma_state_t       state_q;
  dma_state_t       state_d;
  logic [31:0]      src_ptr_q;
  logic [31:0]      dst_ptr_q;
  logic [LEN_W-1:0] remaining_q;
  logic [31:0]      data_buf_q;
  logic             err_q;
  logic             rd_issued_q;
  logic             fill_q;
  logic [31:0]      fill_data_q;

  logic             src_pass_c;
  logic             dst_pass_c;
  logic             range_ok_c;
  logic             fill_sel_c;
  logic             len_zero_c;
  logic             start_ok_c;
  logic [31:0]      src_word_c;
  logic [31:0]      dst_word_c;

  assign src_word_c = {SrcAddr[31:2], 2'b00};
  assign dst_word_c = {DstAddr[31:2], 2'b00};
  assign len_zero_c = (Len == '0);
  assign start_ok_c = Start && (state_q == IDLE);

  big_core_dma_rng_chk #(.LEN_W(LEN_W)) u_src_chk (
    .start_addr (src_word_c),
    .len        (Len),
    .pass_c     (src_pass_c)
  );

  big_core_dma_rng_chk #(.LEN_W(LEN_W)) u_dst_chk (
    .start_addr (dst_word_c),
    .len        (Len),
    .pass_c     (dst_pass_c)
  );

`ifdef BIG_CORE_DMA_FILL_EN
  // Fill never reads, so only the destination has to be in range.
  assign fill_sel_c = FillMode;
  assign range_ok_c = dst_pass_c && (FillMode || src_pass_c);
`else
  logic unused_fill;
  assign unused_fill = ^{FillMode, FillData};
  assign fill_sel_c  = 1'b0;
  assign range_ok_c  = src_pass_c && dst_pass_c;
`endif

  // State register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          if (len_zero_c || !range_ok_c) state_d = DONE;
          else if (fill_sel_c)          state_d = WR;
          else                          state_d = RD;
        end
      end
      RD: begin
        if (DmaGnt) state_d = WR;
      end
      WR: begin
        if (DmaGnt) begin
          if (remaining_q == LEN_W'(1)) state_d = DONE;
          else if (fill_q)              state_d = WR;
          else                          state_d = RD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode; strobes only ever fire with DmaGnt.
  always_comb begin
    Busy             = 1'b0;
    Done             = 1'b0;
    Err              = err_q;
    DmaReq           = 1'b0;
    DMemAddressQ103H = '0;
    DMemWrDataQ103H  = '0;
    DMemByteEnQ103H  = '0;
    DMemWrEnQ103H    = 1'b0;
    DMemRdEnQ103H    = 1'b0;
    case (state_q)
      RD: begin
        Busy   = 1'b1;
        DmaReq = 1'b1;
        if (DmaGnt) begin
          DMemRdEnQ103H    = 1'b1;
          DMemAddressQ103H = src_ptr_q;
        end
      end
      WR: begin
        Busy   = 1'b1;
        DmaReq = 1'b1;
        if (DmaGnt) begin
          DMemWrEnQ103H    = 1'b1;
          DMemAddressQ103H = dst_ptr_q;
          DMemByteEnQ103H  = DMA_WORD_BYTEEN;
          // Response is only on the bus in the first WR cycle; later cycles
          // use the copy captured into data_buf_q.
          if (fill_q)           DMemWrDataQ103H = fill_data_q;
          else if (rd_issued_q) DMemWrDataQ103H = DMemRdRspQ104H;
          else                  DMemWrDataQ103H = data_buf_q;
        end
      end
      DONE: begin
        Busy = 1'b1;
        Done = 1'b1;
      end
      default: ;
    endcase
  end

  // Command latch, pointers, word counter and read-data capture.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      src_ptr_q   <= '0;
      dst_ptr_q   <= '0;
      remaining_q <= '0;
      data_buf_q  <= '0;
      err_q       <= 1'b0;
      rd_issued_q <= 1'b0;
      fill_q      <= 1'b0;
      fill_data_q <= '0;
    end else begin
      rd_issued_q <= (state_q == RD) && DmaGnt;
      if (rd_issued_q) data_buf_q <= DMemRdRspQ104H;
      if (start_ok_c) begin
        err_q       <= !len_zero_c && !range_ok_c;
        src_ptr_q   <= src_word_c;
        dst_ptr_q   <= dst_word_c;
        remaining_q <= Len;
        fill_q      <= fill_sel_c;
`ifdef BIG_CORE_DMA_FILL_EN
        fill_data_q <= FillData;
`else
        fill_data_q <= '0;
`endif
      end else if ((state_q == WR) && DmaGnt) begin
        src_ptr_q   <= src_ptr_q + 32'd4;
        dst_ptr_q   <= dst_ptr_q + 32'd4;
        remaining_q <= remaining_q - LEN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_big_core_dmem_dma.sv
// Directed bench for big_core_dmem_dma with a one-cycle-latency D_MEM model
// and a grant generator that can drop DmaGnt in every response cycle.
module tb_big_core_dmem_dma;

  localparam logic [31:0] DB = 32'h0001_0000;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        Start = 1'b0;
  logic [31:0] SrcAddr = '0;
  logic [31:0] DstAddr = '0;
  logic [15:0] Len = '0;
  logic        FillMode = 1'b0;
  logic [31:0] FillData = '0;
  logic        Busy, Done, Err, DmaReq, DmaGnt;
  logic [31:0] DMemAddressQ103H, DMemWrDataQ103H, DMemRdRspQ104H;
  logic [3:0]  DMemByteEnQ103H;
  logic        DMemWrEnQ103H, DMemRdEnQ103H;

  big_core_dmem_dma #(.LEN_W(16)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .SrcAddr(SrcAddr), .DstAddr(DstAddr),
    .Len(Len), .FillMode(FillMode), .FillData(FillData), .Busy(Busy),
    .Done(Done), .Err(Err), .DmaReq(DmaReq), .DmaGnt(DmaGnt),
    .DMemAddressQ103H(DMemAddressQ103H), .DMemWrDataQ103H(DMemWrDataQ103H),
    .DMemByteEnQ103H(DMemByteEnQ103H), .DMemWrEnQ103H(DMemWrEnQ103H),
    .DMemRdEnQ103H(DMemRdEnQ103H), .DMemRdRspQ104H(DMemRdRspQ104H)
  );

  always #5 Clk = ~Clk;

  int vec = 0;
  int miss = 0;

  // Grant generator: gap_mode drops grant in the cycle after every read.
  logic gap_mode = 1'b0;
  logic last_rd  = 1'b0;
  always @(posedge Clk) last_rd <= DMemRdEnQ103H;
  assign DmaGnt = !(gap_mode && last_rd);

  // D_MEM model, loaded through its own port so only this block writes mem.
  logic [31:0] mem [0:16383];
  logic        load_en = 1'b0;
  logic [13:0] load_idx = '0;
  logic [31:0] load_data = '0;

  function automatic logic [13:0] widx(input logic [31:0] a);
    logic [31:0] t;
    t = a - DB;
    return t[15:2];
  endfunction

  always @(posedge Clk) begin
    if (load_en) mem[load_idx] <= load_data;
    if (DMemRdEnQ103H) DMemRdRspQ104H <= mem[widx(DMemAddressQ103H)];
    if (DMemWrEnQ103H) mem[widx(DMemAddressQ103H)] <= DMemWrDataQ103H;
  end

  // Bus monitor: logs accesses, counts protocol violations.
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } op_t;
  op_t ops[$];
  int  viol = 0;

  always @(negedge Clk) begin
    if (Rst) begin
      if ((DMemRdEnQ103H || DMemWrEnQ103H) && !DmaGnt) viol++;
      if (DMemRdEnQ103H && DMemWrEnQ103H) viol++;
      if (DMemWrEnQ103H && (DMemByteEnQ103H !== 4'hF)) viol++;
      if (DMemRdEnQ103H) ops.push_back('{1'b0, DMemAddressQ103H, 32'h0});
      if (DMemWrEnQ103H) ops.push_back('{1'b1, DMemAddressQ103H, DMemWrDataQ103H});
    end
  end

  task automatic load_word(input logic [31:0] a, input logic [31:0] d);
    @(negedge Clk);
    load_en = 1'b1; load_idx = widx(a); load_data = d;
    @(posedge Clk); #1;
    load_en = 1'b0;
  endtask

  // Issue one command at cycle 0 and step until Done (bounded).
  task automatic run_cmd(input logic [31:0] src, input logic [31:0] dst,
                         input logic [15:0] len, input logic fm,
                         input logic [31:0] fd, input int restart_at,
                         output int done_cyc, output logic err_done,
                         output int busy_cnt);
    @(posedge Clk); #1;
    SrcAddr = src; DstAddr = dst; Len = len; FillMode = fm; FillData = fd;
    Start = 1'b1;
    done_cyc = -1; err_done = 1'b0; busy_cnt = 0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge Clk); #1;
      Start = 1'b0;
      if (k == restart_at) begin Start = 1'b1; Len = 16'd0; end
      if (Busy) busy_cnt++;
      if (Done) begin done_cyc = k; err_done = Err; break; end
    end
    Start = 1'b0;
  endtask

  task automatic test_reset();
    vec++; if (Busy !== 1'b0) begin miss++; $display("FAIL reset_busy got %b want 0", Busy); end
    vec++; if (Done !== 1'b0 || Err !== 1'b0) begin miss++; $display("FAIL reset_done_err got %b%b want 00", Done, Err); end
    vec++; if ({DmaReq, DMemRdEnQ103H, DMemWrEnQ103H} !== 3'b000) begin miss++; $display("FAIL reset_req_strobes got %b want 000", {DmaReq, DMemRdEnQ103H, DMemWrEnQ103H}); end
    vec++; if (DMemAddressQ103H !== 32'h0 || DMemWrDataQ103H !== 32'h0 || DMemByteEnQ103H !== 4'h0) begin miss++; $display("FAIL reset_bus got %h %h %h want 0", DMemAddressQ103H, DMemWrDataQ103H, DMemByteEnQ103H); end
  endtask

  task automatic test_copy();
    int dc, bc, base, v0; logic e;
    base = ops.size(); v0 = viol;
    run_cmd(DB + 32'h100, DB + 32'h200, 16'd4, 1'b0, 32'h0, 0, dc, e, bc);
    vec++; if (dc !== 9) begin miss++; $display("FAIL copy_done_cycle got %0d want 9", dc); end
    vec++; if (e !== 1'b0) begin miss++; $display("FAIL copy_err got %b want 0", e); end
    vec++; if (bc !== 9) begin miss++; $display("FAIL copy_busy_cycles got %0d want 9", bc); end
    vec++; if (ops.size() - base !== 8) begin miss++; $display("FAIL copy_access_count got %0d want 8", ops.size() - base); end
    else begin
      for (int i = 0; i < 4; i++) begin
        vec++;
        if (ops[base+2*i].wr !== 1'b0 || ops[base+2*i].addr !== DB + 32'h100 + 32'(4*i) ||
            ops[base+2*i+1].wr !== 1'b1 || ops[base+2*i+1].addr !== DB + 32'h200 + 32'(4*i) ||
            ops[base+2*i+1].data !== 32'h11111111 * 32'(i+1)) begin
          miss++; $display("FAIL copy_seq word %0d got rd@%h wr@%h data %h", i, ops[base+2*i].addr, ops[base+2*i+1].addr, ops[base+2*i+1].data);
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      vec++; if (mem[widx(DB + 32'h200 + 32'(4*i))] !== 32'h11111111 * 32'(i+1)) begin miss++; $display("FAIL copy_dst word %0d got %h want %h", i, mem[widx(DB + 32'h200 + 32'(4*i))], 32'h11111111 * 32'(i+1)); end
    end
    vec++; if (viol !== v0) begin miss++; $display("FAIL copy_protocol got %0d violations want 0", viol - v0); end
    @(posedge Clk); #1;
    vec++; if (Busy !== 1'b0) begin miss++; $display("FAIL copy_idle_busy got %b want 0", Busy); end
  endtask

  task automatic test_grant_gaps();
    int dc, bc, base, v0, nwr; logic e;
    base = ops.size(); v0 = viol; gap_mode = 1'b1;
    run_cmd(DB + 32'h100, DB + 32'h280, 16'd4, 1'b0, 32'h0, 0, dc, e, bc);
    gap_mode = 1'b0;
    // RD, WR with grant dropped, WR: 3 cycles per word.
    vec++; if (dc !== 13) begin miss++; $display("FAIL gap_done_cycle got %0d want 13", dc); end
    nwr = 0;
    for (int i = base; i < ops.size(); i++) if (ops[i].wr) nwr++;
    vec++; if (nwr !== 4) begin miss++; $display("FAIL gap_write_count got %0d want 4", nwr); end
    for (int i = 0; i < 4; i++) begin
      vec++; if (mem[widx(DB + 32'h280 + 32'(4*i))] !== 32'h11111111 * 32'(i+1)) begin miss++; $display("FAIL gap_dst word %0d got %h want %h", i, mem[widx(DB + 32'h280 + 32'(4*i))], 32'h11111111 * 32'(i+1)); end
    end
    vec++; if (viol !== v0) begin miss++; $display("FAIL gap_protocol got %0d violations want 0", viol - v0); end
  endtask

  task automatic test_len_zero();
    int dc, bc, base; logic e;
    base = ops.size();
    run_cmd(DB + 32'h100, DB + 32'h200, 16'd0, 1'b0, 32'h0, 0, dc, e, bc);
    vec++; if (dc !== 1) begin miss++; $display("FAIL len0_done_cycle got %0d want 1", dc); end
    vec++; if (e !== 1'b0) begin miss++; $display("FAIL len0_err got %b want 0", e); end
    vec++; if (bc !== 1) begin miss++; $display("FAIL len0_busy_cycles got %0d want 1", bc); end
    vec++; if (ops.size() !== base) begin miss++; $display("FAIL len0_accesses got %0d want 0", ops.size() - base); end
    @(posedge Clk); #1;
    vec++; if (Busy !== 1'b0) begin miss++; $display("FAIL len0_idle_busy got %b want 0", Busy); end
  endtask

  task automatic test_range_fail();
    int dc, bc, base; logic e;
    base = ops.size();
    run_cmd(DB + 32'h100, 32'h0001_FFFC, 16'd2, 1'b0, 32'h0, 0, dc, e, bc);
    vec++; if (dc !== 1 || e !== 1'b1) begin miss++; $display("FAIL range_dst got cycle %0d err %b want 1 1", dc, e); end
    vec++; if (ops.size() !== base) begin miss++; $display("FAIL range_dst_accesses got %0d want 0", ops.size() - base); end
    @(posedge Clk); #1;
    vec++; if (Err !== 1'b1) begin miss++; $display("FAIL range_err_sticky got %b want 1", Err); end
    run_cmd(32'h0000_FFFC, DB + 32'h200, 16'd1, 1'b0, 32'h0, 0, dc, e, bc);
    vec++; if (dc !== 1 || e !== 1'b1) begin miss++; $display("FAIL range_src_low got cycle %0d err %b want 1 1", dc, e); end
    run_cmd(32'hFFFF_FFFC, DB + 32'h200, 16'd2, 1'b0, 32'h0, 0, dc, e, bc);
    vec++; if (dc !== 1 || e !== 1'b1) begin miss++; $display("FAIL range_src_wrap got cycle %0d err %b want 1 1", dc, e); end
    vec++; if (ops.size() !== base) begin miss++; $display("FAIL range_accesses got %0d want 0", ops.size() - base); end
    run_cmd(DB + 32'h100, DB + 32'h380, 16'd1, 1'b0, 32'h0, 0, dc, e, bc);
    vec++; if (dc !== 3 || e !== 1'b0) begin miss++; $display("FAIL range_clear got cycle %0d err %b want 3 0", dc, e); end
    vec++; if (mem[widx(DB + 32'h380)] !== 32'h11111111) begin miss++; $display("FAIL range_clear_data got %h want 11111111", mem[widx(DB + 32'h380)]); end
  endtask

  task automatic test_start_ignored();
    int dc, bc; logic e;
    run_cmd(DB + 32'h108, DB + 32'h3C0, 16'd2, 1'b0, 32'h0, 2, dc, e, bc);
    vec++; if (dc !== 5 || bc !== 5) begin miss++; $display("FAIL busy_start got cycle %0d busy %0d want 5 5", dc, bc); end
    vec++; if (mem[widx(DB + 32'h3C4)] !== 32'h44444444) begin miss++; $display("FAIL busy_start_data got %h want 44444444", mem[widx(DB + 32'h3C4)]); end
  endtask

  task automatic test_fill();
    int dc, bc, base, nrd; logic e;
    base = ops.size();
    run_cmd(DB + 32'h100, DB + 32'h40, 16'd3, 1'b1, 32'hDEADBEEF, 0, dc, e, bc);
    nrd = 0;
    for (int i = base; i < ops.size(); i++) if (!ops[i].wr) nrd++;
`ifdef BIG_CORE_DMA_FILL_EN
    vec++; if (dc !== 4) begin miss++; $display("FAIL fill_done_cycle got %0d want 4", dc); end
    vec++; if (nrd !== 0 || ops.size() - base !== 3) begin miss++; $display("FAIL fill_accesses got %0d rd %0d total want 0 3", nrd, ops.size() - base); end
    for (int i = 0; i < 3; i++) begin
      vec++; if (mem[widx(DB + 32'h40 + 32'(4*i))] !== 32'hDEADBEEF) begin miss++; $display("FAIL fill_dst word %0d got %h want deadbeef", i, mem[widx(DB + 32'h40 + 32'(4*i))]); end
    end
`else
    // Fill inputs are ignored: an ordinary 3-word copy.
    vec++; if (dc !== 7) begin miss++; $display("FAIL nofill_done_cycle got %0d want 7", dc); end
    vec++; if (nrd !== 3) begin miss++; $display("FAIL nofill_reads got %0d want 3", nrd); end
    for (int i = 0; i < 3; i++) begin
      vec++; if (mem[widx(DB + 32'h40 + 32'(4*i))] !== 32'h11111111 * 32'(i+1)) begin miss++; $display("FAIL nofill_dst word %0d got %h want %h", i, mem[widx(DB + 32'h40 + 32'(4*i))], 32'h11111111 * 32'(i+1)); end
    end
`endif
  endtask

  task automatic test_reset_mid();
    int base; logic seen_done, seen_busy;
    base = ops.size();
    @(posedge Clk); #1;
    SrcAddr = DB + 32'h100; DstAddr = DB + 32'h300; Len = 16'd4; FillMode = 1'b0;
    Start = 1'b1;
    for (int k = 1; k <= 4; k++) begin @(posedge Clk); #1; Start = 1'b0; end
    // Cycle 4 is the WR of the second word.
    vec++; if (DMemWrEnQ103H !== 1'b1) begin miss++; $display("FAIL mid_wr_before_reset got %b want 1", DMemWrEnQ103H); end
    Rst = 1'b0; #1;
    vec++; if ({Busy, Done, Err, DmaReq, DMemRdEnQ103H, DMemWrEnQ103H} !== 6'b0 ||
               DMemAddressQ103H !== 32'h0 || DMemWrDataQ103H !== 32'h0 || DMemByteEnQ103H !== 4'h0) begin
      miss++; $display("FAIL mid_reset_outputs got %b addr %h data %h want all 0", {Busy, Done, Err, DmaReq, DMemRdEnQ103H, DMemWrEnQ103H}, DMemAddressQ103H, DMemWrDataQ103H);
    end
    repeat (2) @(posedge Clk);
    @(negedge Clk); Rst = 1'b1;
    seen_done = 1'b0; seen_busy = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge Clk); #1;
      if (Done) seen_done = 1'b1;
      if (Busy) seen_busy = 1'b1;
    end
    vec++; if (seen_done !== 1'b0 || seen_busy !== 1'b0) begin miss++; $display("FAIL mid_after_release got done %b busy %b want 0 0", seen_done, seen_busy); end
    vec++; if (ops.size() - base !== 3) begin miss++; $display("FAIL mid_accesses got %0d want 3", ops.size() - base); end
    vec++; if (mem[widx(DB + 32'h300)] !== 32'h11111111) begin miss++; $display("FAIL mid_word0 got %h want 11111111", mem[widx(DB + 32'h300)]); end
    for (int i = 1; i < 4; i++) begin
      vec++; if (mem[widx(DB + 32'h300 + 32'(4*i))] !== 32'h0) begin miss++; $display("FAIL mid_untouched word %0d got %h want 0", i, mem[widx(DB + 32'h300 + 32'(4*i))]); end
    end
  endtask

  initial begin
    #1;
    test_reset();
    repeat (2) @(posedge Clk);
    @(negedge Clk); Rst = 1'b1;
    for (int i = 0; i < 4; i++) load_word(DB + 32'h100 + 32'(4*i), 32'h11111111 * 32'(i+1));
    for (int i = 0; i < 4; i++) load_word(DB + 32'h40 + 32'(4*i), 32'h0);
    for (int i = 0; i < 128; i++) load_word(DB + 32'h200 + 32'(4*i), 32'h0);
    test_copy();
    test_grant_gaps();
    test_len_zero();
    test_range_fail();
    test_start_ignored();
    test_fill();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
